// File: rtl/fp16_dot_accumulator.sv
// Reduces groups of up to VEC_LEN FP16 products into one FP16 sum.
// The add is approximate: capped alignment, truncation, single-step normalisation.
module fp16_dot_accumulator #(
   parameter int VEC_LEN      = 8,
   parameter int APPROX_ALIGN = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_data,
   input  logic        in_last,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_data,
   output logic [7:0]  out_count,
   output logic        out_ovf
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [7:0] VEC_LEN_C = 8'(VEC_LEN);
   localparam logic [4:0] ALIGN_C   = 5'(APPROX_ALIGN);

   state_t      state_r;
   state_t      state_next_s;
   logic [15:0] acc_r;
   logic [7:0]  cnt_r;
   logic        ovf_r;
   logic        out_valid_r;
   logic        in_ready_r;
   logic        accept_s;
   logic [7:0]  cnt_inc_s;
   logic [16:0] add_res_s;

   // Returns {saturated, fp16 result} of the approximate add.
   function automatic logic [16:0] fp16_add(input logic [15:0] x, input logic [15:0] y);
      logic        x_big;
      logic [15:0] l_op;
      logic [15:0] s_op;
      logic [4:0]  diff;
      logic [4:0]  sh;
      logic [10:0] m_l;
      logic [10:0] m_s;
      logic [11:0] sum;
      logic [5:0]  e;
      logic [9:0]  mant;
      logic [16:0] res;
      x_big = (x[14:10] > y[14:10]) ||
              ((x[14:10] == y[14:10]) && (x[9:0] >= y[9:0]));
      l_op  = x_big ? x : y;
      s_op  = x_big ? y : x;
      diff  = l_op[14:10] - s_op[14:10];
      sh    = (diff > ALIGN_C) ? ALIGN_C : diff;
      m_l   = {(l_op[14:10] != 5'd0), l_op[9:0]};
      m_s   = {(s_op[14:10] != 5'd0), s_op[9:0]} >> sh;
      if (l_op[15] == s_op[15]) begin
         sum = {1'b0, m_l} + {1'b0, m_s};
      end else begin
         sum = {1'b0, m_l} - {1'b0, m_s};
      end
      if (sum[11]) begin
         e    = {1'b0, l_op[14:10]} + 6'd1;
         mant = sum[10:1];
      end else if (sum[10]) begin
         e    = {1'b0, l_op[14:10]};
         mant = sum[9:0];
      end else begin
         // Only one left step: deeper cancellation keeps truncated precision.
         e    = {1'b0, l_op[14:10]} - 6'd1;
         mant = {sum[8:0], 1'b0};
      end
      if (sum == 12'd0) begin
         res = 17'd0;
      end else if (l_op[14:10] == 5'd0) begin
         res = {1'b0, l_op[15], 15'd0};
      end else if ((e >= 6'd31) || (l_op[14:10] == 5'd31)) begin
         res = {1'b1, l_op[15], 5'h1F, 10'h000};
      end else begin
         res = {1'b0, l_op[15], e[4:0], mant};
      end
      return res;
   endfunction

   assign accept_s  = in_valid && in_ready_r;
   assign cnt_inc_s = cnt_r + 8'd1;
   assign add_res_s = fp16_add(acc_r, in_data);

   // Next-state decode for the group FSM.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               if (in_last || (VEC_LEN_C == 8'd1)) begin
                  state_next_s = DONE;
               end else begin
                  state_next_s = ACCUM;
               end
            end else begin
               state_next_s = IDLE;
            end
         end
         ACCUM: begin
            if (accept_s) begin
               if (in_last || (cnt_inc_s == VEC_LEN_C)) begin
                  state_next_s = DONE;
               end else begin
                  state_next_s = ACCUM;
               end
            end else begin
               state_next_s = ACCUM;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = DONE;
            end
         end
         default: state_next_s = IDLE;
      endcase
   end

   // State, accumulator and registered handshake outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         acc_r       <= 16'h0000;
         cnt_r       <= 8'd0;
         ovf_r       <= 1'b0;
         out_valid_r <= 1'b0;
         in_ready_r  <= 1'b1;
      end else begin
         state_r     <= state_next_s;
         out_valid_r <= (state_next_s == DONE);
         in_ready_r  <= (state_next_s != DONE);
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  acc_r <= in_data;
                  cnt_r <= 8'd1;
                  ovf_r <= 1'b0;
               end
            end
            ACCUM: begin
               if (accept_s) begin
                  acc_r <= add_res_s[15:0];
                  cnt_r <= cnt_inc_s;
                  ovf_r <= ovf_r | add_res_s[16];
               end
            end
            DONE: begin
               acc_r <= acc_r;
            end
            default: begin
               acc_r <= 16'h0000;
               cnt_r <= 8'd0;
               ovf_r <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign out_data  = acc_r;
   assign out_count = cnt_r;
   assign out_ovf   = ovf_r;

endmodule

// File: doc/fp16_dot_accumulator.md
Name: fp16_dot_accumulator

Overview:
- Downstream consumer of the FP16 approximate multiplier in the PE datapath.
- Takes a stream of FP16 products over a valid/ready handshake and reduces each group of up to VEC_LEN products into one FP16 dot-product value.
- Reduction uses the team's approximate FP16 add: capped alignment shift, truncation, and single-step left normalisation.
- Each finished sum is presented on a registered valid/ready output towards the result buffer.

Parameters:
- VEC_LEN, 8: maximum products per group; legal range 1..255. A group closes on the VEC_LEN-th accepted element or on in_last, whichever comes first.
- APPROX_ALIGN, 4: maximum right-shift applied to the smaller operand's mantissa during alignment.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data and in_last are valid.
- in_ready  output  1  block accepts input this cycle.
- in_data  input  16  FP16 product {sign, exp[4:0], mant[9:0]}.
- in_last  input  1  marks the final element of the current group.
- out_valid  output  1  out_data and out_count are valid.
- out_ready  input  1  downstream accepts the output.
- out_data  output  16  FP16 group sum.
- out_count  output  8  number of elements accumulated into out_data (1..VEC_LEN).
- out_ovf  output  1  set if any add in the group saturated to exponent 31.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE; accumulator and element counter are cleared.
  - Outputs after reset: out_valid=0, out_data=0x0000, out_count=0, out_ovf=0, in_ready=1.
  - Reset mid-group or mid-output discards all partial state with no output; it takes priority over every other event.
- Accept: an element is accepted when in_valid && in_ready on a rising edge. in_ready=1 in IDLE and ACCUM, 0 in DONE.
- State IDLE:
  - On accept, acc <= in_data, cnt <= 1, ovf <= 0. The first element is loaded, not added.
  - Next state is DONE if in_last or VEC_LEN==1, else ACCUM.
- State ACCUM:
  - On accept, acc <= add(acc, in_data), cnt <= cnt+1, ovf |= saturation flag.
  - Go to DONE if in_last or cnt+1==VEC_LEN.
  - With no accept, all state holds.
- State DONE:
  - out_valid=1; out_data=acc, out_count=cnt and out_ovf=ovf are registered and held stable while out_ready=0.
  - On out_ready, go to IDLE next cycle. Exactly one bubble cycle between groups; input is never accepted in the same cycle as the output handshake.
- Latency: out_valid rises on the cycle after the closing element is accepted. Throughput is 1 element/cycle within a group.
- add(x, y), combinational, one per cycle:
  - Operand ordering: x is larger iff exp_x > exp_y, or exp_x == exp_y and mant_x >= mant_y. L = larger operand, S = smaller.
  - Implicit bit: the leading bit is 1 if exp != 0, else 0 (11-bit mantissas).
  - Alignment: shift = min(exp_L - exp_S, APPROX_ALIGN); S mantissa is logically right-shifted by shift. Shifted-out bits are dropped with no rounding.
  - Mantissa: sum = M_L + M_S if signs match, else M_L - M_S (12-bit). Result sign = sign_L.
  - If sum == 0, result = 0x0000 (+0).
  - Normalisation on the 12-bit sum, using a 6-bit exponent intermediate e:
    - sum[11]=1: e = exp_L+1, mant = sum[10:1].
    - else sum[10]=1: e = exp_L, mant = sum[9:0].
    - else: e = exp_L-1, mant = {sum[8:0], 1'b0}.
  - Zero handling: if exp_L == 0, result = sign_L with exp 0, mant 0.
  - Saturation: if e >= 31 or exp_L == 31, result = {sign_L, 5'h1F, 10'h000} and the saturation flag is set. NaN is not propagated.
- in_data is ignored whenever in_ready=0. in_last is ignored when in_valid=0.

Test Plan:
- Eight 0x3C00 (1.0) back-to-back, in_last on the 8th -> intermediate acc 0x4000, 0x4200, 0x4400, 0x4500, 0x4600, 0x4700; final out_data=0x4800, out_count=8, out_ovf=0, out_valid one cycle after the 8th accept.
- 0x3C00 then 0xBC00 with in_last -> out_data=0x0000, out_count=2.
- 0x3C00 then 0x1400 (2^-10) with in_last -> shift capped at 4; out_data=0x3C40 (approximation check).
- 0x7BFF then 0x7BFF with in_last -> out_data=0x7C00, out_ovf=1; the next group starts with out_ovf cleared.
- Group of 3 with out_ready held low 3 cycles -> out_valid, out_data and out_count stable, in_ready=0 throughout; after the handshake, in_ready=1 after exactly one bubble cycle.
- rst asserted after 5 accepts of a group -> no out_valid; all outputs at reset values next cycle; a new 2-element group 0x4000+0x4000 then gives 0x4400.
